bell_round_ctrl: RTL

- Round sequencer for the two-player bell game.
- Per round it:
  - deals a card pair,
  - opens a timed bell window with a countdown,
  - accepts the first keypad press (key 7 = player A, key 9 = player B),
  - judges the press against the bell rule,
  - emits one scoring word to the score file,
  - checks the win margin.
- Sits between the keypad/card display and the score accumulator. It drives the round-level sequencing that the rule, press and score logic need.

---
 rtl/bell_round_ctrl_pkg.sv | 47 ++++
 rtl/bell_round_ctrl_lfsr.sv | 34 +++
 rtl/bell_round_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bell_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bell_round_ctrl_pkg
// Description : Shared constants for the bell-game round sequencer: FSM
//               encoding, keypad codes, bell rule number, winner codes,
//               penalty bytes and the raw-to-card-number mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package bell_round_ctrl_pkg;

    // Round sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_DEAL     = 3'd2;
    localparam logic [2:0] ST_OPEN     = 3'd3;
    localparam logic [2:0] ST_JUDGE    = 3'd4;
    localparam logic [2:0] ST_SCORE    = 3'd5;
    localparam logic [2:0] ST_CHECK    = 3'd6;
    localparam logic [2:0] ST_GAMEOVER = 3'd7;

    // Keypad codes owned by each player
    localparam logic [3:0] KEY_A = 4'd7;
    localparam logic [3:0] KEY_B = 4'd9;

    // The bell rings when the matching-colour numbers sum to this value,
    // or when either number equals it for mixed colours
    localparam logic [3:0] RULE_NUM = 4'd5;

    // Winner / presser codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // A wrong press costs the presser one point and gifts the opponent one
    localparam logic [7:0] PENALTY_POS = 8'h01;
    localparam logic [7:0] PENALTY_NEG = 8'hFF;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fold a raw 3-bit value onto card numbers 1..5
    function automatic logic [2:0] map_num(input logic [2:0] raw);
        return (raw <= 3'd4) ? (raw + 3'd1) : (raw - 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bell_round_ctrl_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : card_lfsr
// Description : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) free-running every
//               cycle; supplies raw bits for random card dealing.
// Revision    : 1.0 - initial release
// ============================================================================
module card_lfsr
    import bell_round_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    // Taps 8,6,5,4 map to state bits 7,5,4,3; the seed keeps it off all-zero
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Advance one step every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/bell_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bell_round_ctrl
// Description : Round sequencer for the two-player bell game. Deals cards,
//               runs the timed bell window, takes the first keypad press,
//               judges it, emits one score word and checks the win margin.
// Revision    : 1.0 - initial release
// ============================================================================
module bell_round_ctrl
    import bell_round_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int WINDOW_TICKS = 100,
    parameter int WIN_MARGIN   = 50,
    parameter int MAX_ROUNDS   = 20,
    parameter int SETTLE       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  keypad_in,
    input  logic        test_card_en,
    input  logic [9:0]  test_card,
    input  logic [15:0] total_score,
    output logic [1:0]  c1,
    output logic [1:0]  c2,
    output logic [2:0]  n1,
    output logic [2:0]  n2,
    output logic [7:0]  count,
    output logic [15:0] add_score,
    output logic        add_valid,
    output logic        score_clr,
    output logic [4:0]  round_cnt,
    output logic [1:0]  winner,
    output logic        game_over
);

    localparam int c_pre_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_set_w = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_set_w-1:0] c_settle   = c_set_w'(SETTLE);

    logic [2:0]         r_state;
    logic [1:0]         r_c1, r_c2;
    logic [2:0]         r_n1, r_n2;
    logic [7:0]         r_count;
    logic [c_pre_w-1:0] r_pre;
    logic [4:0]         r_round;
    logic [1:0]         r_winner;
    logic [1:0]         r_who;
    logic               r_right;
    logic [c_set_w-1:0] r_settle;
    logic [3:0]         r_key_prev;

    logic [7:0] w_lfsr;
    logic       w_press;
    logic       w_same;
    logic [3:0] w_sum;
    logic       w_right;
    logic [8:0] w_a9, w_b9, w_margin;
    logic       w_a_wins, w_b_wins;

    card_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (w_lfsr)
    );

    // A press is a fresh arrival of a player key; held keys never re-fire
    assign w_press = ((keypad_in == KEY_A) || (keypad_in == KEY_B)) &&
                     (keypad_in != r_key_prev);

    // Bell rule on the displayed pair; sum kept at 4 bits so 5+5 cannot alias
    assign w_same  = (r_c1 == r_c2);
    assign w_sum   = {1'b0, r_n1} + {1'b0, r_n2};
    assign w_right = w_same ? (w_sum == RULE_NUM)
                            : (({1'b0, r_n1} == RULE_NUM) || ({1'b0, r_n2} == RULE_NUM));

    // Margin comparison widened to 9 bits so the addition never wraps
    assign w_a9     = {1'b0, total_score[7:0]};
    assign w_b9     = {1'b0, total_score[15:8]};
    assign w_margin = 9'(WIN_MARGIN);
    assign w_a_wins = w_a9 > (w_b9 + w_margin);
    assign w_b_wins = w_b9 > (w_a9 + w_margin);

    // Previous keypad code for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_prev <= 4'd0;
        end else begin
            r_key_prev <= keypad_in;
        end
    end

    // Round sequencer and its datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_c1     <= 2'd0;
            r_c2     <= 2'd0;
            r_n1     <= 3'd0;
            r_n2     <= 3'd0;
            r_count  <= 8'd0;
            r_pre    <= '0;
            r_round  <= 5'd0;
            r_winner <= WIN_NONE;
            r_who    <= WIN_NONE;
            r_right  <= 1'b0;
            r_settle <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_round  <= 5'd0;
                    r_winner <= WIN_NONE;
                    r_state  <= ST_DEAL;
                end
                ST_DEAL: begin
                    if (test_card_en) begin
                        r_c1 <= test_card[9:8];
                        r_c2 <= test_card[7:6];
                        r_n1 <= test_card[5:3];
                        r_n2 <= test_card[2:0];
                    end else begin
                        r_c1 <= w_lfsr[1:0];
                        r_c2 <= w_lfsr[3:2];
                        r_n1 <= map_num(w_lfsr[6:4]);
                        r_n2 <= map_num({w_lfsr[7], w_lfsr[1], w_lfsr[3]});
                    end
                    r_count <= 8'(WINDOW_TICKS);
                    r_pre   <= '0;
                    r_round <= r_round + 5'd1;
                    r_state <= ST_OPEN;
                end
                ST_OPEN: begin
                    // A press beats an expiring window, and freezes count
                    if (w_press) begin
                        r_who   <= (keypad_in == KEY_A) ? WIN_A : WIN_B;
                        r_state <= ST_JUDGE;
                    end else if (r_count == 8'd0) begin
                        r_settle <= '0;
                        r_state  <= ST_CHECK;
                    end else if (r_pre == c_pre_last) begin
                        r_pre   <= '0;
                        r_count <= r_count - 8'd1;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                ST_JUDGE: begin
                    r_right <= w_right;
                    r_state <= ST_SCORE;
                end
                ST_SCORE: begin
                    r_settle <= '0;
                    r_state  <= ST_CHECK;
                end
                ST_CHECK: begin
                    // Give the score file time to absorb the last delta
                    if (r_settle == c_settle) begin
                        if (w_a_wins) begin
                            r_winner <= WIN_A;
                            r_state  <= ST_GAMEOVER;
                        end else if (w_b_wins) begin
                            r_winner <= WIN_B;
                            r_state  <= ST_GAMEOVER;
                        end else if (r_round == 5'(MAX_ROUNDS)) begin
                            r_winner <= WIN_DRAW;
                            r_state  <= ST_GAMEOVER;
                        end else begin
                            r_state <= ST_DEAL;
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_GAMEOVER: begin
                    if (start) begin
                        r_state <= ST_CLEAR;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Score word is only driven during the single SCORE cycle
    always_comb begin
        add_score = 16'h0000;
        if (r_state == ST_SCORE) begin
            if (r_who == WIN_A) begin
                add_score = r_right ? {8'h00, r_count} : {PENALTY_POS, PENALTY_NEG};
            end else begin
                add_score = r_right ? {r_count, 8'h00} : {PENALTY_NEG, PENALTY_POS};
            end
        end
    end

    assign add_valid = (r_state == ST_SCORE);
    assign score_clr = (r_state == ST_CLEAR);
    assign game_over = (r_state == ST_GAMEOVER);
    assign c1        = r_c1;
    assign c2        = r_c2;
    assign n1        = r_n1;
    assign n2        = r_n2;
    assign count     = r_count;
    assign round_cnt = r_round;
    assign winner    = r_winner;

endmodule
`default_nettype wire
